// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : IDLE (round-robin scan) / LOCK (burst owner holds the port)
//   rr_next     : index + 1 with wrap at n
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of every non-clock signal around the FIFO write-port arbiter.
//   req/req_data/req_last : requester side, one lane per requester
//   gnt                   : per-requester beat accept (one-hot or zero)
//   wr_en/wdata           : to the FIFO write port
//   full/overflow         : from the FIFO, write-clock domain
//   err/err_clr           : sticky overflow flag and its synchronous clear
//   owner/locked          : debug view of the arbiter state
// slave  : the arbiter itself
// master : the environment (requesters + FIFO)
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       gnt;
    logic                  wr_en;
    logic [WIDTH-1:0]      wdata;
    logic                  full;
    logic                  overflow;
    logic                  err;
    logic                  err_clr;
    logic [IW-1:0]         owner;
    logic                  locked;

    modport slave (
        input  req, req_data, req_last, full, overflow, err_clr,
        output gnt, wr_en, wdata, err, owner, locked
    );

    modport master (
        output req, req_data, req_last, full, overflow, err_clr,
        input  gnt, wr_en, wdata, err, owner, locked
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   ptr_i  : highest-priority index this cycle
//   pick_o : one-hot winner (zero when nothing requested)
//   idx_o  : winner index
//   any_o  : at least one request present
module fifo_wr_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default at the top,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        // Scan ptr, ptr+1, ... with wrap; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        pick_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters,
// with locked bursts (ended by req_last or after MAX_BURST beats).
//   wr_clk_i : FIFO write clock, the only clock here
//   rst_ni   : asynchronous active-low reset
//   bus      : arbiter side of fifo_wr_arbiter_if (requests, FIFO port, status)
// gnt/wr_en/wdata are combinational from registered state and req/full,
// so an accepted beat appears on the FIFO port in the same cycle.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 wr_clk_i,
    input  logic                 rst_ni,
    fifo_wr_arbiter_if.slave     bus
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] gnt_s;
    logic [WIDTH-1:0] wdata_s;
    logic            wr_en_s;
    logic            last_sel;

    fifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i  (bus.req),
        .ptr_i  (ptr_q),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge wr_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Output logic: grant, write enable and data mux.
    // Gated by rst_ni so the port is quiet while reset is held, even though
    // the registered state alone would let an IDLE scan grant.
    always_comb begin
        gnt_s   = '0;
        wdata_s = '0;
        if (rst_ni && !bus.full) begin
            if (state_q == IDLE) begin
                gnt_s = pick_oh;
            end else if (bus.req[owner_q]) begin
                gnt_s = NREQ'(1) << owner_q;
            end
        end
        wr_en_s = |gnt_s;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                wdata_s = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
        last_sel = |(gnt_s & bus.req_last);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        // Overflow wins over a same-cycle clear.
        err_d   = bus.overflow | (err_q & ~bus.err_clr);

        unique case (state_q)
            IDLE: begin
                if (wr_en_s) begin
                    owner_d = pick_idx;
                    if (last_sel || MAX_BURST == 1) begin
                        ptr_d = IW'(rr_next(int'(pick_idx), NREQ));
                    end else begin
                        state_d = LOCK;
                        beat_d  = BW'(1);
                    end
                end
            end
            LOCK: begin
                if (wr_en_s) begin
                    if (last_sel || beat_q == BW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        ptr_d   = IW'(rr_next(int'(owner_q), NREQ));
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (!bus.req[owner_q]) begin
                    // Owner abandoned its burst: release without a beat.
                    state_d = IDLE;
                    ptr_d   = IW'(rr_next(int'(owner_q), NREQ));
                    beat_d  = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt    = gnt_s;
    assign bus.wr_en  = wr_en_s;
    assign bus.wdata  = wdata_s;
    assign bus.err    = err_q;
    assign bus.owner  = owner_q;
    assign bus.locked = (state_q == LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .MAX_BURST (MAXB)
    ) dut (
        .wr_clk_i (clk),
        .rst_ni   (rst_n),
        .bus      (bus)
    );

    // Expected outputs for one cycle.
    typedef struct {
        int               gnt_idx;   // -1 = no beat
        logic [WIDTH-1:0] data;
        logic             locked;
        int               owner;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    // Reference model: priority list that is rotated on release, plus the
    // current burst holder and its beat count.
    int   m_order[$];
    int   m_lock;
    int   m_beats;
    int   m_last;
    int   m_gnt;
    logic m_err;

    logic [WIDTH-1:0] dat [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_order.delete();
        for (int i = 0; i < NREQ; i++) m_order.push_back(i);
        m_lock  = -1;
        m_beats = 0;
        m_last  = 0;
        m_gnt   = -1;
        m_err   = 1'b0;
    endtask

    // Rotate the priority list until r is last (r+1 becomes first).
    task automatic release_to_back(input int r);
        while (m_order[$] != r) m_order.push_back(m_order.pop_front());
    endtask

    // Predict this cycle's outputs from the driven inputs, then advance.
    task automatic model_cycle();
        exp_t e;
        int   r;
        e.locked = (m_lock >= 0);
        e.owner  = m_last;
        e.err    = m_err;
        m_gnt    = -1;
        if (m_lock >= 0) begin
            r = m_lock;
            if (!bus.req[r]) begin
                m_lock = -1;
                release_to_back(r);
            end else if (!bus.full) begin
                m_gnt = r;
                m_beats++;
                if (bus.req_last[r] || m_beats == MAXB) begin
                    m_lock = -1;
                    release_to_back(r);
                end
            end
        end else if (!bus.full) begin
            foreach (m_order[k]) begin
                if (m_gnt < 0 && bus.req[m_order[k]]) m_gnt = m_order[k];
            end
            if (m_gnt >= 0) begin
                m_last = m_gnt;
                if (bus.req_last[m_gnt] || MAXB == 1) begin
                    release_to_back(m_gnt);
                end else begin
                    m_lock  = m_gnt;
                    m_beats = 1;
                end
            end
        end
        e.gnt_idx = m_gnt;
        e.data    = (m_gnt >= 0) ? dat[m_gnt] : '0;
        m_err     = bus.overflow ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the expectation.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                         input logic f, input logic ov, input logic cl);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = dat[i];
        bus.req      = r;
        bus.req_last = l;
        bus.full     = f;
        bus.overflow = ov;
        bus.err_clr  = cl;
        model_cycle();
        if (m_gnt >= 0) dat[m_gnt] = dat[m_gnt] + 1'b1;
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("gnt", 32'(bus.gnt), (e.gnt_idx >= 0) ? (32'd1 << e.gnt_idx) : 32'd0);
                    check("wr_en", 32'(bus.wr_en), 32'(e.gnt_idx >= 0));
                    check("wdata", 32'(bus.wdata), 32'(e.data));
                    check("locked", 32'(bus.locked), 32'(e.locked));
                    check("owner", 32'(bus.owner), 32'(e.owner));
                    check("err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    initial begin : stimulus
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] lastv;
        int  b2;
        logic r1;

        rst_n        = 1'b0;
        bus.req      = '1;
        bus.req_last = '1;
        bus.req_data = '1;
        bus.full     = 1'b0;
        bus.overflow = 1'b0;
        bus.err_clr  = 1'b0;
        for (int i = 0; i < NREQ; i++) dat[i] = WIDTH'(i * 16);
        model_reset();

        // Reset: port quiet even with every requester asserting.
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wdata", 32'(bus.wdata), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        bus.req = '0;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 1: all requesting single beats -> 0,1,2,3,0.
        repeat (5) cycle(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);

        // 2: 6-beat burst from requester 2 capped at 4, requester 1 cuts in.
        b2 = 6;
        r1 = 1'b0;
        for (int c = 0; c < 16 && (b2 > 0 || r1); c++) begin
            cycle({1'b0, b2 > 0, r1, 1'b0}, {1'b0, b2 == 1, 1'b1, 1'b0}, 1'b0, 1'b0, 1'b0);
            if (m_gnt == 2) b2--;
            if (m_gnt == 1) r1 = 1'b0;
            if (c == 0) r1 = 1'b1;
        end
        cycle('0, '0, 1'b0, 1'b0, 1'b0);

        // 3: burst from 0 stalled by full while requester 3 waits.
        cycle(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1001, 4'b1000, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(4'b1001, 4'b1000, 1'b1, 1'b0, 1'b0);
        cycle(4'b1001, 4'b1000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
        cycle(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);

        // 4: owner 1 abandons its burst, requester 3 follows.
        cycle(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);

        // 5: sticky error, clear, and overflow beating a same-cycle clear.
        cycle('0, '0, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle('0, '0, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b1, 1'b1);
        repeat (2) cycle('0, '0, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);

        // 6: reset asserted while locked.
        cycle(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("t6_locked_before", 32'(bus.locked), 32'd1);
        check("t6_gnt_before", 32'(bus.gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(bus.gnt), 32'd0);
        check("t6_wr_en", 32'(bus.wr_en), 32'd0);
        check("t6_owner", 32'(bus.owner), 32'd0);
        check("t6_locked", 32'(bus.locked), 32'd0);
        bus.req = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        cycle(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);

        // Random traffic; requests and their data/last held until granted.
        pend  = '0;
        lastv = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i]  = 1'b1;
                    lastv[i] = ($urandom_range(0, 2) == 0);
                    dat[i]   = WIDTH'($urandom);
                end
            end
            cycle(pend, lastv, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
            if (m_gnt >= 0) pend[m_gnt] = 1'b0;
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
